pc_fetch: RTL



---
 rtl/pc_fetch_pkg.sv | 15 +
 rtl/pc_fetch.sv | 113 +++++++++++
 2 files changed

// File: rtl/pc_fetch_pkg.sv
// rtl/pc_fetch_pkg.sv - shared fetch state encodings and default vector addresses
package pc_fetch_pkg;

    typedef enum logic [1:0] {
        FS_REQ  = 2'd0,
        FS_WAIT = 2'd1,
        FS_OUT  = 2'd2,
        FS_DROP = 2'd3
    } fetch_state_t;

    // Word addresses: byte 0x0000_3000 reset entry, byte 0x0001_0600 exception entry.
    localparam logic [31:2] DEF_RESET_PC = 30'h0000_0C00;
    localparam logic [31:2] DEF_EXC_PC   = 30'h0000_4180;

endpackage

// File: rtl/pc_fetch.sv
// rtl/pc_fetch.sv - instruction fetch front end with PC register; optional FETCH_EPC_EN builds the epc register
module pc_fetch
    import pc_fetch_pkg::*;
#(
    parameter logic [31:2] RESET_PC = DEF_RESET_PC,
    parameter logic [31:2] EXC_PC   = DEF_EXC_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:2] npc,
    input  logic        exc_req,
    output logic        imem_req,
    output logic [31:2] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:2] pc,
    output logic [31:2] epc
);

    fetch_state_t state, state_nxt;
    logic [31:2]  pc_nxt;
    logic [31:0]  inst_nxt;
    logic         req_en;
    logic         gnt_ok;

    // Holds off the first request until one clock after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_en <= 1'b0;
        end else begin
            req_en <= 1'b1;
        end
    end

    assign imem_req   = (state == FS_REQ) && req_en;
    assign imem_addr  = pc;
    assign inst_valid = (state == FS_OUT);
    assign gnt_ok     = imem_req && imem_gnt;

    // Next-state, next-pc and instruction capture; exceptions override everything.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        inst_nxt  = inst;
        if (exc_req) begin
            pc_nxt = EXC_PC;
            case (state)
                FS_REQ:  state_nxt = gnt_ok ? FS_DROP : FS_REQ;
                FS_WAIT: state_nxt = imem_rvalid ? FS_REQ : FS_DROP;
                FS_OUT:  state_nxt = FS_REQ;
                FS_DROP: state_nxt = FS_DROP;
                default: state_nxt = FS_REQ;
            endcase
        end else begin
            case (state)
                FS_REQ: begin
                    if (gnt_ok) begin
                        state_nxt = FS_WAIT;
                    end
                end
                FS_WAIT: begin
                    if (imem_rvalid) begin
                        inst_nxt  = imem_rdata;
                        state_nxt = FS_OUT;
                    end
                end
                FS_OUT: begin
                    if (inst_ready) begin
                        pc_nxt    = npc;
                        state_nxt = FS_REQ;
                    end
                end
                FS_DROP: begin
                    if (imem_rvalid) begin
                        state_nxt = FS_REQ;
                    end
                end
                default: state_nxt = FS_REQ;
            endcase
        end
    end

    // State, PC and instruction registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FS_REQ;
            pc    <= RESET_PC;
            inst  <= 32'h0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            inst  <= inst_nxt;
        end
    end

`ifdef FETCH_EPC_EN
    // Records the PC that was interrupted, before the redirect lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            epc <= '0;
        end else if (exc_req) begin
            epc <= pc;
        end
    end
`else
    assign epc = '0;
`endif

endmodule
